// File: rtl/apb_multi_slave_mem_if.sv
// apb_multi_slave_mem_if: APB bus bundle between one requester and the multi-window memory.
//   master modport: drives pselx/penable/pwrite/paddr/pwdata/pstrb/pprot/wait_states,
//                   observes pready/prdata/pslverr/fsm_state.
//   slave modport:  the reverse direction of every signal.
interface apb_multi_slave_mem_if #(
    parameter int NO_OF_SLAVES  = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [NO_OF_SLAVES-1:0]   pselx;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic [3:0]                wait_states;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;
    logic [2:0]                fsm_state;
    modport master (
        output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, wait_states,
        input  pready, prdata, pslverr, fsm_state
    );
    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, wait_states,
        output pready, prdata, pslverr, fsm_state
    );
endinterface

// File: rtl/apb_multi_slave_mem.sv
// apb_multi_slave_mem: APB completer exposing NO_OF_SLAVES memory windows separated by unmapped gaps.
//   pclk   : clock
//   preset : asynchronous active-high reset (clears state and all memory)
//   apb    : slave modport carrying the APB request, programmable wait states,
//            pready/prdata/pslverr response and the fsm_state observation port
module apb_multi_slave_mem #(
    parameter int NO_OF_SLAVES      = 4,
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int SLAVE_MEM_BYTES   = 64,
    parameter int SLAVE_GAP_BYTES   = 16,
    parameter int SECURE_PROT_CHECK = 1
) (
    input logic pclk,
    input logic preset,
    apb_multi_slave_mem_if.slave apb
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int WORDS  = SLAVE_MEM_BYTES / BYTES;
    localparam int STRIDE = SLAVE_MEM_BYTES + SLAVE_GAP_BYTES;
    localparam int SH     = $clog2(BYTES);
    localparam int HB     = $clog2(SLAVE_MEM_BYTES) - 1;
    localparam int IW     = $clog2(NO_OF_SLAVES * WORDS) > 0 ? $clog2(NO_OF_SLAVES * WORDS) : 1;
    typedef enum logic [2:0] {
        NO_STATE   = 3'd0,
        IDLE       = 3'd1,
        SETUP      = 3'd2,
        ACCESS     = 3'd3,
        WAIT_STATE = 3'd4
    } state_t;
    state_t                   state_q;
    logic [3:0]               cnt_q;
    logic [NO_OF_SLAVES-1:0]  sel_q;
    logic                     wr_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [BYTES-1:0]         strb_q;
    logic [IW-1:0]            idx_q;
    logic [IW-1:0]            idx_d;
    logic [DATA_WIDTH-1:0]    mem_q [NO_OF_SLAVES*WORDS];
    logic                     setup;
    logic                     err_d;
    logic                     onehot;
    logic                     in_win;
    logic                     secure;
    logic [ADDRESS_WIDTH-1:0] base;
    logic [ADDRESS_WIDTH-1:0] offset;
    int                       k;
    logic                     unused_prot;
    assign unused_prot = ^{apb.pprot[2], apb.pprot[0]};
    assign setup = (state_q == IDLE || state_q == ACCESS) && |apb.pselx && !apb.penable;
    // Decode the lowest selected window; a non-one-hot select is flagged as an error,
    // so the chosen index only matters for legal requests.
    always_comb begin
        k = 0;
        for (int i = NO_OF_SLAVES - 1; i >= 0; i--)
            if (apb.pselx[i]) k = i;
        base   = ADDRESS_WIDTH'(k * STRIDE);
        offset = apb.paddr - base;
        onehot = |apb.pselx && ((apb.pselx & (apb.pselx - NO_OF_SLAVES'(1))) == '0);
        in_win = (apb.paddr >= base) && (offset < ADDRESS_WIDTH'(SLAVE_MEM_BYTES));
        secure = (SECURE_PROT_CHECK != 0) && apb.pprot[1] && offset[HB];
        err_d  = !onehot || !in_win || (!apb.pwrite && |apb.pstrb) || secure;
        idx_d  = IW'(k * WORDS) + IW'(offset >> SH);
    end
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            strb_q  <= '0;
            idx_q   <= '0;
            for (int i = 0; i < NO_OF_SLAVES * WORDS; i++) mem_q[i] <= '0;
        end else if (setup) begin
            state_q <= (apb.wait_states == 4'd0) ? ACCESS : WAIT_STATE;
            cnt_q   <= apb.wait_states;
            sel_q   <= apb.pselx;
            wr_q    <= apb.pwrite;
            err_q   <= err_d;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
            idx_q   <= idx_d;
            // Read data is captured here so a read right after a completed write sees it.
            rdata_q <= err_d ? '0 : mem_q[idx_d];
        end else begin
            case (state_q)
                WAIT_STATE: begin
                    state_q <= (!apb.penable || apb.pselx != sel_q) ? IDLE :
                               (cnt_q == 4'd1) ? ACCESS : WAIT_STATE;
                    cnt_q   <= cnt_q - 4'd1;
                end
                ACCESS: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    if (apb.penable && apb.pselx == sel_q && wr_q && !err_q)
                        for (int b = 0; b < BYTES; b++)
                            if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
    assign apb.pready    = state_q == ACCESS;
    assign apb.pslverr   = (state_q == ACCESS) && err_q;
    assign apb.prdata    = (state_q == ACCESS && !err_q && !wr_q) ? rdata_q : '0;
    assign apb.fsm_state = setup ? SETUP : state_q;
endmodule

// File: tb/tb_apb_multi_slave_mem.sv
// tb_apb_multi_slave_mem: directed APB transfers checked every cycle against an address-arithmetic model.
module tb_apb_multi_slave_mem;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    apb_multi_slave_mem_if #(.NO_OF_SLAVES(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)) apb ();
    apb_multi_slave_mem dut (.pclk(clk), .preset(rst), .apb(apb));
    int n_chk = 0;
    int n_fail = 0;
    logic        exp_rdy, exp_err;
    logic [31:0] exp_rd;
    logic [2:0]  exp_state;
    logic [31:0] mm [4][16];
    logic [31:0] last_rd;
    logic        last_err;
    int          last_wait;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("pready", 32'(apb.pready), 32'(exp_rdy));
        chk("pslverr", 32'(apb.pslverr), 32'(exp_err));
        chk("prdata", apb.prdata, exp_rd);
        chk("fsm_state", 32'(apb.fsm_state), 32'(exp_state));
    end
    function automatic logic m_err(input logic [3:0] sel, input logic [31:0] a, input logic wr,
                                   input logic [3:0] st, input logic [2:0] pr);
        int lo;
        if ($countones(sel) != 1) return 1'b1;
        lo = $clog2(sel) * 80;
        if (int'(a) < lo || int'(a) >= lo + 64) return 1'b1;
        if (!wr && st != 4'd0) return 1'b1;
        if (pr[1] && int'(a) - lo >= 32) return 1'b1;
        return 1'b0;
    endfunction
    task automatic idle_exp();
        exp_state = 3'd1; exp_rdy = 1'b0; exp_err = 1'b0; exp_rd = '0;
    endtask
    task automatic xfer(input logic [3:0] sel, input logic [31:0] a, input logic wr, input logic [31:0] d,
                        input logic [3:0] st, input logic [2:0] pr, input logic [3:0] ws);
        logic e;
        logic [31:0] rd;
        int kk, w;
        e = m_err(sel, a, wr, st, pr);
        kk = $clog2(sel);
        w = (int'(a) - kk * 80) / 4;
        rd = '0;
        if (!wr && !e) rd = mm[kk][w];
        apb.pselx = sel; apb.penable = 1'b0; apb.paddr = a; apb.pwrite = wr;
        apb.pwdata = d; apb.pstrb = st; apb.pprot = pr; apb.wait_states = ws;
        exp_state = 3'd2; exp_rdy = 1'b0; exp_err = 1'b0; exp_rd = '0;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        apb.wait_states = ~ws;
        last_wait = 0;
        for (int i = 0; i < int'(ws); i++) begin
            exp_state = 3'd4;
            @(negedge clk);
            if (apb.pready === 1'b0) last_wait++;
            @(posedge clk); #1;
        end
        exp_state = 3'd3; exp_rdy = 1'b1; exp_err = e; exp_rd = rd;
        @(negedge clk);
        last_rd = apb.prdata;
        last_err = apb.pslverr;
        @(posedge clk);
        if (wr && !e)
            for (int b = 0; b < 4; b++)
                if (st[b]) mm[kk][w][8*b +: 8] = d[8*b +: 8];
        #1;
        apb.pselx = '0; apb.penable = 1'b0;
        idle_exp();
    endtask
    initial begin
        rst = 1'b1;
        apb.pselx = '0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0;
        apb.pwdata = '0; apb.pstrb = '0; apb.pprot = '0; apb.wait_states = '0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 16; j++) mm[i][j] = '0;
        idle_exp();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        xfer(4'b0010, 32'd88, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0);
        chk("wr88_err", 32'(last_err), 32'd0);
        chk("model_88", mm[1][2], 32'hDEADBEEF);
        xfer(4'b0010, 32'd88, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("rd88", last_rd, 32'hDEADBEEF);
        xfer(4'b0010, 32'd88, 1'b1, 32'h11223344, 4'b0101, 3'b000, 4'd0);
        xfer(4'b0010, 32'd88, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("rd88_strb", last_rd, 32'hDE22BE44);
        chk("model_88_strb", mm[1][2], 32'hDE22BE44);
        xfer(4'b0010, 32'd100, 1'b1, 32'hA5A50F0F, 4'hF, 3'b000, 4'd3);
        chk("wait3_wr", 32'(last_wait), 32'd3);
        xfer(4'b0010, 32'd100, 1'b0, 32'h0, 4'h0, 3'b000, 4'd3);
        chk("wait3_rd", 32'(last_wait), 32'd3);
        chk("rd100", last_rd, 32'hA5A50F0F);
        xfer(4'b0001, 32'd70, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 4'd0);
        chk("gap_err", 32'(last_err), 32'd1);
        xfer(4'b0010, 32'd84, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("gap_nowrite", last_rd, 32'h0);
        xfer(4'b0011, 32'd8, 1'b1, 32'h12345678, 4'hF, 3'b000, 4'd0);
        chk("multisel_err", 32'(last_err), 32'd1);
        xfer(4'b0001, 32'd8, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("multisel_nowrite", last_rd, 32'h0);
        xfer(4'b0010, 32'd88, 1'b0, 32'h0, 4'hF, 3'b000, 4'd0);
        chk("rdstrb_err", 32'(last_err), 32'd1);
        chk("rdstrb_data", last_rd, 32'h0);
        xfer(4'b0100, 32'd192, 1'b1, 32'hCAFEF00D, 4'hF, 3'b010, 4'd0);
        chk("sec_err", 32'(last_err), 32'd1);
        xfer(4'b0100, 32'd192, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("sec_nowrite", last_rd, 32'h0);
        xfer(4'b0100, 32'd192, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 4'd0);
        chk("sec_ok", 32'(last_err), 32'd0);
        xfer(4'b0100, 32'd192, 1'b0, 32'h0, 4'h0, 3'b000, 4'd1);
        chk("sec_rd", last_rd, 32'hCAFEF00D);
        xfer(4'b0100, 32'd192, 1'b0, 32'h0, 4'h0, 3'b010, 4'd0);
        chk("sec_rd_err", 32'(last_err), 32'd1);
        xfer(4'b0100, 32'd188, 1'b1, 32'h0BADCAFE, 4'hF, 3'b010, 4'd0);
        chk("nonsec_lower", 32'(last_err), 32'd0);
        xfer(4'b0100, 32'd196, 1'b1, 32'h87654321, 4'hF, 3'b101, 4'd2);
        chk("prot_ignored", 32'(last_err), 32'd0);
        xfer(4'b0100, 32'd223, 1'b1, 32'h5A5A5A5A, 4'hF, 3'b000, 4'd0);
        xfer(4'b0100, 32'd220, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("top_word", last_rd, 32'h5A5A5A5A);
        xfer(4'b0100, 32'd224, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("past_top_err", 32'(last_err), 32'd1);
        xfer(4'b0100, 32'd188, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("rd188", last_rd, 32'h0BADCAFE);
        xfer(4'b0100, 32'd196, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("rd196", last_rd, 32'h87654321);
        // abort: penable and pselx dropped during a wait cycle
        apb.pselx = 4'b0010; apb.penable = 1'b0; apb.paddr = 32'd96; apb.pwrite = 1'b1;
        apb.pwdata = 32'h77777777; apb.pstrb = 4'hF; apb.pprot = 3'b000; apb.wait_states = 4'd2;
        exp_state = 3'd2;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        exp_state = 3'd4;
        @(posedge clk); #1;
        apb.pselx = '0; apb.penable = 1'b0;
        @(posedge clk); #1;
        idle_exp();
        @(posedge clk); #1;
        xfer(4'b0010, 32'd96, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("abort_nowrite", last_rd, 32'h0);
        // reset pulsed during a wait cycle of a write
        apb.pselx = 4'b0010; apb.penable = 1'b0; apb.paddr = 32'd88; apb.pwrite = 1'b1;
        apb.pwdata = 32'h12345678; apb.pstrb = 4'hF; apb.pprot = 3'b000; apb.wait_states = 4'd5;
        exp_state = 3'd2;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        exp_state = 3'd4;
        @(posedge clk); #2;
        rst = 1'b1;
        idle_exp();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 16; j++) mm[i][j] = '0;
        #1;
        chk("rst_async_state", 32'(apb.fsm_state), 32'd1);
        chk("rst_async_rdy", 32'(apb.pready), 32'd0);
        apb.pselx = '0; apb.penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        xfer(4'b0010, 32'd88, 1'b0, 32'h0, 4'h0, 3'b000, 4'd0);
        chk("rst_cleared_88", last_rd, 32'h0);
        chk("rst_first_ok", 32'(last_err), 32'd0);
        xfer(4'b0100, 32'd196, 1'b0, 32'h0, 4'h0, 3'b000, 4'd1);
        chk("rst_cleared_196", last_rd, 32'h0);
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
